// File: rtl/spi_sensor_reg_target_if.sv
// SPI link between the Nios II SPI master and the sensor register target.
// The master drives clock, data-out and select. The target returns serial data
// and an output enable for the shared MISO line.
interface spi_sensor_reg_target_if;
  logic SCLK;
  logic MOSI;
  logic SS_n;
  logic MISO;
  logic MISO_oe;

  modport master (
    output SCLK,
    output MOSI,
    output SS_n,
    input  MISO,
    input  MISO_oe
  );

  modport slave (
    input  SCLK,
    input  MOSI,
    input  SS_n,
    output MISO,
    output MISO_oe
  );
endinterface

// File: rtl/spi_sensor_reg_target.sv
// SPI mode-0 responder that stands in for the image-sensor register interface.
// Frame layout: command byte (0x02 write, 0x03 read), a 16-bit address sent MSB
// byte first, then data bytes. The address auto-increments after every data byte.
// Committed writes are mirrored on the reg_wr_* strobe bus.
// The fabric has its own registered read port into the same register file.
// Address 0 holds a read-only ID byte.
// All SPI activity is suppressed while xclr_i is low.
// ADDR_W is supported from 1 to 16 bits.
module spi_sensor_reg_target #(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] ID_VALUE = 8'h5C
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  spi_sensor_reg_target_if.slave spi,
  input  logic                  xclr_i,
  output logic                  reg_wr_valid,
  output logic [ADDR_W-1:0]     reg_wr_addr,
  output logic [7:0]            reg_wr_data,
  input  logic [ADDR_W-1:0]     cfg_rd_addr,
  output logic [7:0]            cfg_rd_data,
  output logic                  busy,
  output logic                  err_cmd
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_H,
    ADDR_L,
    WDATA,
    RDATA,
    IGNORE
  } state_t;

  // Synchronisers. The extra SCLK stage keeps the previous synchronised level
  // for edge detection.
  logic [2:0]        sclk_sync_reg;
  logic [1:0]        mosi_sync_reg;
  logic [1:0]        ss_n_sync_reg;

  state_t            state_reg;
  logic              sel_prev_reg;
  logic [2:0]        bit_cnt_reg;
  logic [6:0]        rx_sh_reg;
  logic [7:0]        tx_sh_reg;
  logic              cmd_rd_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              oe_reg;
  logic              wr_valid_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;
  logic              err_cmd_reg;
  logic [7:0]        cfg_rd_data_reg;

  logic [7:0]        mem_reg [DEPTH];

  logic              sclk_rise;
  logic              sclk_fall;
  logic              mosi_s;
  logic              sel;
  logic              byte_done;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_cur;
  logic [ADDR_W-1:0] ptr_inc;
  logic              mem_we;

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
  assign mosi_s    = mosi_sync_reg[1];
  assign sel       = ~ss_n_sync_reg[1] & xclr_i;

  // The byte completes on the 8th rise. MOSI is taken straight from the
  // synchroniser, so the completed byte can be used in the same cycle.
  assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);
  assign rx_byte   = {rx_sh_reg, mosi_s};
  assign ptr_inc   = ptr_reg + 1'b1;

  // Writes to address 0 are dropped. This keeps the ID byte constant.
  assign mem_we = sel && (state_reg == WDATA) && byte_done && (ptr_reg != '0);

  // Input synchronisers. SS_n starts deasserted so that leaving reset does not
  // look like a select edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      ss_n_sync_reg <= '1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[1:0], spi.SCLK};
      mosi_sync_reg <= {mosi_sync_reg[0], spi.MOSI};
      ss_n_sync_reg <= {ss_n_sync_reg[0], spi.SS_n};
    end
  end

  // Only address bits that fit in ADDR_W are kept from the high address byte.
  // For ADDR_W <= 8 the high byte is discarded entirely.
  generate
    if (ADDR_W > 8) begin : g_addr_hi
      logic [ADDR_W-9:0] addr_hi_reg;

      // Capture the kept bits of the high address byte.
      always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
          addr_hi_reg <= '0;
        end else if (sel && (state_reg == ADDR_H) && byte_done) begin
          addr_hi_reg <= rx_byte[ADDR_W-9:0];
        end
      end

      assign addr_cur = {addr_hi_reg, rx_byte};
    end else begin : g_addr_lo
      assign addr_cur = rx_byte[ADDR_W-1:0];
    end
  endgenerate

  // Register file: one write port from the WDATA path, plus a registered fabric
  // read port. The fabric port returns the old data when a write to the same
  // address commits in the same cycle.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= (i == 0) ? ID_VALUE : 8'h00;
      end
      cfg_rd_data_reg <= '0;
    end else begin
      if (mem_we) begin
        mem_reg[ptr_reg] <= rx_byte;
      end
      cfg_rd_data_reg <= mem_reg[cfg_rd_addr];
    end
  end

  // Transaction FSM with bit shifters, address pointer and registered strobes.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg    <= IDLE;
      sel_prev_reg <= 1'b0;
      bit_cnt_reg  <= '0;
      rx_sh_reg    <= '0;
      tx_sh_reg    <= '0;
      cmd_rd_reg   <= 1'b0;
      ptr_reg      <= '0;
      oe_reg       <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      err_cmd_reg  <= 1'b0;
    end else begin
      sel_prev_reg <= sel;
      oe_reg       <= sel;
      wr_valid_reg <= 1'b0;
      err_cmd_reg  <= 1'b0;

      if (!sel) begin
        // Deselect or sensor clear abandons the frame, including any partial byte.
        state_reg   <= IDLE;
        bit_cnt_reg <= '0;
        rx_sh_reg   <= '0;
        tx_sh_reg   <= '0;
      end else begin
        if (state_reg != IDLE) begin
          if (sclk_rise) begin
            rx_sh_reg   <= rx_byte[6:0];
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
          end
          // The fall that follows a byte boundary (bit count back at 0) must not
          // shift. Otherwise the freshly loaded MSB would be lost before the
          // master samples it.
          if (sclk_fall && (bit_cnt_reg != 3'd0)) begin
            tx_sh_reg <= {tx_sh_reg[6:0], 1'b0};
          end
        end

        case (state_reg)
          IDLE: begin
            if (!sel_prev_reg) begin
              state_reg <= CMD;
            end
          end
          CMD: begin
            if (byte_done) begin
              if ((rx_byte == CMD_WRITE) || (rx_byte == CMD_READ)) begin
                cmd_rd_reg <= (rx_byte == CMD_READ);
                state_reg  <= ADDR_H;
              end else begin
                err_cmd_reg <= 1'b1;
                state_reg   <= IGNORE;
              end
            end
          end
          ADDR_H: begin
            if (byte_done) begin
              state_reg <= ADDR_L;
            end
          end
          ADDR_L: begin
            if (byte_done) begin
              ptr_reg <= addr_cur;
              if (cmd_rd_reg) begin
                tx_sh_reg <= mem_reg[addr_cur];
                state_reg <= RDATA;
              end else begin
                state_reg <= WDATA;
              end
            end
          end
          WDATA: begin
            if (byte_done) begin
              if (mem_we) begin
                wr_valid_reg <= 1'b1;
                wr_addr_reg  <= ptr_reg;
                wr_data_reg  <= rx_byte;
              end
              ptr_reg <= ptr_inc;
            end
          end
          RDATA: begin
            if (byte_done) begin
              tx_sh_reg <= mem_reg[ptr_inc];
              ptr_reg   <= ptr_inc;
            end
          end
          IGNORE: begin
            // Nothing is loaded into tx_sh here, so MISO stays low.
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign spi.MISO     = tx_sh_reg[7];
  assign spi.MISO_oe  = oe_reg;
  assign reg_wr_valid = wr_valid_reg;
  assign reg_wr_addr  = wr_addr_reg;
  assign reg_wr_data  = wr_data_reg;
  assign cfg_rd_data  = cfg_rd_data_reg;
  assign busy         = (state_reg != IDLE);
  assign err_cmd      = err_cmd_reg;

endmodule

// File: tb/tb_spi_sensor_reg_target.sv
// Bench for spi_sensor_reg_target.
// It drives the DUT as an SPI mode-0 master with directed and random frames.
// Responses are compared against a byte-array model of the register file.
module tb_spi_sensor_reg_target;

  localparam int HALF = 5;  // SCLK half-period in clk_clk cycles

  logic       clk;
  logic       reset_reset;
  logic       xclr_i;
  logic       reg_wr_valid;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic [7:0] cfg_rd_addr;
  logic [7:0] cfg_rd_data;
  logic       busy;
  logic       err_cmd;

  spi_sensor_reg_target_if spi_bus ();

  spi_sensor_reg_target #(
    .ADDR_W   (8),
    .ID_VALUE (8'h5C)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (reset_reset),
    .spi          (spi_bus),
    .xclr_i       (xclr_i),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .cfg_rd_addr  (cfg_rd_addr),
    .cfg_rd_data  (cfg_rd_data),
    .busy         (busy),
    .err_cmd      (err_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          txn_id   = 0;
  int          err_cnt  = 0;
  logic [15:0] obs_wr [$];
  logic [7:0]  model_mem [256];
  logic [7:0]  tx_buf [16];
  logic [7:0]  rx_buf [16];
  logic        oe_min;
  logic        oe_max;

  // Records every write strobe and error pulse as seen by the fabric.
  always @(negedge clk) begin
    if (reg_wr_valid) obs_wr.push_back({reg_wr_addr, reg_wr_data});
    if (err_cmd) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One byte, MSB first. MISO is sampled just before each rising edge.
  // nbits < 8 clocks only the leading bits.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 7; b >= 8 - nbits; b--) begin
      spi_bus.MOSI = tx[b];
      repeat (HALF) @(negedge clk);
      rx[b] = spi_bus.MISO;
      if (spi_bus.MISO_oe) oe_max = 1'b1;
      else oe_min = 1'b0;
      spi_bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_bus.SCLK = 1'b0;
    end
  endtask

  task automatic spi_txn(input int n_bytes, input int abort_bits, output logic busy_end);
    oe_min = 1'b1;
    oe_max = 1'b0;
    spi_bus.SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n_bytes; i++) begin
      spi_byte(tx_buf[i], (i == n_bytes - 1 && abort_bits > 0) ? abort_bits : 8, rx_buf[i]);
    end
    repeat (3) @(negedge clk);
    busy_end = busy;
    spi_bus.SS_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("oe_idle", 32'(spi_bus.MISO_oe), 32'd0);
    check_eq("miso_idle", 32'(spi_bus.MISO), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic cfg_read(input logic [7:0] a, output logic [7:0] d);
    cfg_rd_addr = a;
    @(negedge clk);
    d = cfg_rd_data;
  endtask

  // Runs one frame whose data bytes are already in tx_buf[3..]. The model
  // predicts strobes, read-back bytes and the error pulse, then checks them.
  task automatic do_txn(input logic [7:0] cmd, input logic [15:0] addr, input int n_data,
                        input int abort_bits, input logic xclr);
    logic [7:0]  exp_rd [8];
    logic [15:0] exp_wr [8];
    logic [7:0]  a;
    logic [7:0]  d;
    logic        busy_end;
    logic        active;
    logic        valid;
    int          n_full;
    int          n_exp_wr;
    int          base_wr;
    int          base_err;

    tx_buf[0] = cmd;
    tx_buf[1] = addr[15:8];
    tx_buf[2] = addr[7:0];
    active    = xclr;
    valid     = (cmd == 8'h02) || (cmd == 8'h03);
    n_full    = (abort_bits > 0) ? n_data - 1 : n_data;
    n_exp_wr  = 0;
    a         = addr[7:0];
    for (int i = 0; i < n_full; i++) begin
      exp_rd[i] = (active && cmd == 8'h03) ? model_mem[a] : 8'h00;
      if (active && cmd == 8'h02 && a != 8'h00) begin
        exp_wr[n_exp_wr] = {a, tx_buf[3+i]};
        n_exp_wr++;
        model_mem[a] = tx_buf[3+i];
      end
      a = a + 8'd1;
    end

    base_wr  = obs_wr.size();
    base_err = err_cnt;
    txn_id++;
    $display("txn %0d: cmd=%02h addr=%04h data_bytes=%0d abort_bits=%0d xclr=%0d",
             txn_id, cmd, addr, n_data, abort_bits, xclr);
    xclr_i = xclr;
    spi_txn(3 + n_data, abort_bits, busy_end);
    xclr_i = 1'b1;

    check_eq("busy_active", 32'(busy_end), 32'(active));
    check_eq("oe_min", 32'(oe_min), 32'(active));
    check_eq("oe_max", 32'(oe_max), 32'(active));
    check_eq("hdr_miso", 32'({rx_buf[0], rx_buf[1], rx_buf[2]}), 32'd0);
    for (int i = 0; i < n_full; i++) begin
      check_eq("rd_byte", 32'(rx_buf[3+i]), 32'(exp_rd[i]));
    end
    check_eq("wr_count", 32'(obs_wr.size() - base_wr), 32'(n_exp_wr));
    for (int i = 0; i < n_exp_wr; i++) begin
      if (base_wr + i < obs_wr.size()) begin
        check_eq("wr_strobe", 32'(obs_wr[base_wr+i]), 32'(exp_wr[i]));
      end
    end
    check_eq("err_cmd", 32'(err_cnt - base_err), 32'(active && !valid));

    a = addr[7:0] + 8'($urandom_range(0, n_data));
    cfg_read(a, d);
    check_eq("cfg_rd", 32'(d), 32'(model_mem[a]));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, limit 5000000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [7:0]  cmd;
    logic [15:0] addr;
    int          n_data;
    int          abort_bits;
    logic        xclr;

    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_mem[0] = 8'h5C;

    reset_reset  = 1'b1;
    xclr_i       = 1'b1;
    spi_bus.SCLK = 1'b0;
    spi_bus.MOSI = 1'b0;
    spi_bus.SS_n = 1'b1;
    cfg_rd_addr  = 8'h00;
    repeat (4) @(negedge clk);

    check_eq("rst_cfg_rd", 32'(cfg_rd_data), 32'd0);
    check_eq("rst_wr_valid", 32'(reg_wr_valid), 32'd0);
    check_eq("rst_wr_addr_data", 32'({reg_wr_addr, reg_wr_data}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err_cmd), 32'd0);
    check_eq("rst_miso", 32'({spi_bus.MISO, spi_bus.MISO_oe}), 32'd0);

    reset_reset = 1'b0;
    @(negedge clk);
    cfg_read(8'h00, d);
    check_eq("rst_id", 32'(d), 32'h5C);
    cfg_read(8'h10, d);
    check_eq("rst_mem10", 32'(d), 32'h00);

    // Write A5, 3C starting at 0x10.
    tx_buf[3] = 8'hA5;
    tx_buf[4] = 8'h3C;
    do_txn(8'h02, 16'h0010, 2, 0, 1'b1);
    cfg_read(8'h11, d);
    check_eq("tp_cfg11", 32'(d), 32'h3C);

    // Read the two bytes back with dummy data.
    tx_buf[3] = 8'h00;
    tx_buf[4] = 8'hFF;
    do_txn(8'h03, 16'h0010, 2, 0, 1'b1);
    check_eq("tp_rd10", 32'(rx_buf[3]), 32'hA5);
    check_eq("tp_rd11", 32'(rx_buf[4]), 32'h3C);

    // ID register, and a dropped write to address 0.
    do_txn(8'h03, 16'h0000, 1, 0, 1'b1);
    check_eq("tp_id_spi", 32'(rx_buf[3]), 32'h5C);
    tx_buf[3] = 8'hFF;
    do_txn(8'h02, 16'h0000, 1, 0, 1'b1);
    do_txn(8'h03, 16'h0000, 1, 0, 1'b1);
    check_eq("tp_id_after_wr", 32'(rx_buf[3]), 32'h5C);

    // Address wrap: 0xFF is written, 0x00 is dropped, 0x01 is untouched.
    tx_buf[3] = 8'h77;
    tx_buf[4] = 8'h88;
    do_txn(8'h02, 16'h00FF, 2, 0, 1'b1);
    do_txn(8'h03, 16'h0001, 1, 0, 1'b1);
    check_eq("tp_wrap_01", 32'(rx_buf[3]), 32'h00);
    cfg_read(8'hFF, d);
    check_eq("tp_wrap_ff", 32'(d), 32'h77);

    // Illegal command.
    tx_buf[3] = 8'h12;
    tx_buf[4] = 8'h34;
    tx_buf[5] = 8'h56;
    do_txn(8'h07, 16'h0020, 3, 0, 1'b1);

    // Abort 5 bits into a data byte, then the same write with xclr low.
    tx_buf[3] = 8'h99;
    do_txn(8'h02, 16'h0030, 1, 5, 1'b1);
    cfg_read(8'h30, d);
    check_eq("tp_abort_mem", 32'(d), 32'h00);
    do_txn(8'h02, 16'h0030, 1, 0, 1'b0);
    cfg_read(8'h30, d);
    check_eq("tp_xclr_mem", 32'(d), 32'h00);

    // Random frames.
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cmd = 8'h02;
        4, 5, 6, 7: cmd = 8'h03;
        default:    cmd = 8'($urandom);
      endcase
      addr[15:8] = 8'($urandom);
      case ($urandom_range(0, 5))
        0:       addr[7:0] = 8'hFF;
        1:       addr[7:0] = 8'hFE;
        2:       addr[7:0] = 8'h00;
        default: addr[7:0] = 8'($urandom_range(0, 31));
      endcase
      n_data     = $urandom_range(1, 4);
      abort_bits = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
      xclr       = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 4; i++) tx_buf[3+i] = 8'($urandom);
      do_txn(cmd, addr, n_data, abort_bits, xclr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
